univ_shift_reg: RTL

Parametrised universal shift register: N-bit register supporting hold, shift right, shift left and parallel load, with independent serial inputs and outputs at both ends. A built-in shift counter flags each completed N-bit word, so the block can serialise and deserialise words directly. It is the general-purpose shifting element for serial links and bit-banged peripherals on the board, replacing fixed-direction free-running shifters.

---
 rtl/univ_shift_reg_pkg.sv | 10 +
 rtl/univ_shift_reg_cnt.sv | 20 ++
 rtl/univ_shift_reg.sv | 50 +++++
 3 files changed

// File: rtl/univ_shift_reg_pkg.sv
// univ_shift_reg_pkg: mode encodings and counter width rule shared by the shift register slice
package univ_shift_reg_pkg;
   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;
   function automatic int cnt_width(input int n);
      return $clog2(n);
   endfunction
endpackage

// File: rtl/univ_shift_reg_cnt.sv
// mod_n_counter: modulo-N event counter with a terminal-count wrap flag
module mod_n_counter
   import univ_shift_reg_pkg::*;
#(
   parameter int N = 8,
   localparam int CW = cnt_width(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] cnt,
   output logic          wrap
);
   assign wrap = inc && !clr && cnt == CW'(N - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (inc) cnt <= wrap ? '0 : cnt + CW'(1);
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: N-bit hold/shift-right/shift-left/load register with word completion pulse
module univ_shift_reg
   import univ_shift_reg_pkg::*;
#(
   parameter int N = 8,
   localparam int CW = cnt_width(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic [1:0]    mode,
   input  logic          s_in_r,
   input  logic          s_in_l,
   input  logic [N-1:0]  d_in,
   output logic [N-1:0]  q,
   output logic          s_out_r,
   output logic          s_out_l,
   output logic          word_done,
   output logic [CW-1:0] shift_cnt
);
   logic shift, wrap;
   logic [N-1:0] q_nxt;
   assign shift = mode == MODE_SHR || mode == MODE_SHL;
   assign s_out_r = q[0];
   assign s_out_l = q[N-1];
   always_comb
      q_nxt = mode == MODE_SHR  ? {s_in_r, q[N-1:1]} :
              mode == MODE_SHL  ? {q[N-2:0], s_in_l} :
              mode == MODE_LOAD ? d_in : q;
   // a load restarts the word, so it clears the counter like clr does
   mod_n_counter #(.N(N)) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr || mode == MODE_LOAD),
      .inc  (shift),
      .cnt  (shift_cnt),
      .wrap (wrap)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         q         <= '0;
         word_done <= 1'b0;
      end else if (clr) begin
         q         <= '0;
         word_done <= 1'b0;
      end else begin
         q         <= q_nxt;
         word_done <= wrap;
      end
endmodule
